// File: rtl/mac_ants_sched.sv
// mac_ants beam scheduler.
// Holds one antenna vector per handshake. Sweeps up to NBEAM codebook words
// and feeds {vector, code word} pairs to mac_ants. Returned beam sums are
// tagged with beam index, sop and eop.
// Optional statistics ports are enabled by defining MAC_ANTS_SCHED_STAT_EN.
module mac_ants_sched #(
    parameter int ANT     = 32,
    parameter int IW      = 32,
    parameter int OW      = 48,
    parameter int NBEAM   = 16,
    parameter int BW      = 4,
    parameter int CB_LAT  = 1,
    parameter int MAC_LAT = 10
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [ANT*IW-1:0]   i_ants_data,
    input  logic                i_rvalid,
    output logic                o_ready,
    input  logic [BW:0]         i_nbeam,
    output logic [BW-1:0]       o_cb_addr,
    output logic                o_cb_rden,
    input  logic [ANT*IW-1:0]   i_cb_data,
    output logic [ANT*IW-1:0]   o_mac_ants_data,
    output logic [ANT*IW-1:0]   o_mac_code_word,
    output logic                o_mac_valid,
    input  logic [2*OW-1:0]     i_mac_sum,
    output logic                o_tvalid,
    output logic [2*OW-1:0]     o_tdata,
    output logic [BW-1:0]       o_beam_idx,
    output logic                o_sop,
`ifdef MAC_ANTS_SCHED_STAT_EN
    output logic [15:0]         o_vec_cnt,
    output logic                o_busy,
`endif
    output logic                o_eop
);

    localparam int DW = ANT * IW;
    localparam logic [BW:0] NB_MAX = (BW+1)'(NBEAM);
    localparam logic [BW:0] NB_ONE = (BW+1)'(1);

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic          valid;
        logic [BW-1:0] idx;
        logic          sop;
        logic          eop;
    } tag_t;

    state_t          state;
    logic [BW:0]     nb_q;
    logic [DW-1:0]   hold;
    logic            accept;
    logic [BW:0]     nb_in;
    logic            last;
    logic [BW-1:0]   addr_next;
    tag_t            iss;
    tag_t            cb_tag  [CB_LAT];
    logic [DW-1:0]   cb_vec  [CB_LAT];
    tag_t            mac_tag;
    tag_t            res_tag [MAC_LAT];

    // Handshake, beam-count clamp and tag for the beam issued this cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        accept    = i_rvalid && o_ready;
        nb_in     = (i_nbeam == '0 || i_nbeam > NB_MAX) ? NB_MAX : i_nbeam;
        last      = ({1'b0, o_cb_addr} == nb_q - NB_ONE);
        addr_next = o_cb_addr + BW'(1);
        iss       = '0;
        iss.valid = o_cb_rden;
        iss.idx   = o_cb_addr;
        iss.sop   = (o_cb_addr == '0);
        iss.eop   = last;
    end

    // Sweep FSM: accepts vectors and issues one codebook read per cycle.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (i_reset) begin
            state     <= IDLE;
            o_ready   <= 1'b1;
            o_cb_rden <= 1'b0;
            o_cb_addr <= '0;
            nb_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= RUN;
                        nb_q      <= nb_in;
                        o_cb_rden <= 1'b1;
                        o_cb_addr <= '0;
                        o_ready   <= (nb_in == NB_ONE);
                    end
                end
                RUN: begin
                    if (last) begin
                        if (accept) begin
                            nb_q      <= nb_in;
                            o_cb_addr <= '0;
                            o_ready   <= (nb_in == NB_ONE);
                        end else begin
                            state     <= IDLE;
                            o_cb_rden <= 1'b0;
                            o_cb_addr <= '0;
                            o_ready   <= 1'b1;
                        end
                    end else begin
                        o_cb_addr <= addr_next;
                        o_ready   <= ({1'b0, addr_next} == nb_q - NB_ONE);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Vector hold register and its copy travelling beside the codebook read.
    always_ff @(posedge i_clk) begin
        // NOTE: pure data registers need no reset; the valid bits alone qualify them.
        if (accept) hold <= i_ants_data;
        cb_vec[0] <= hold;
        for (int i = 1; i < CB_LAT; i++) cb_vec[i] <= cb_vec[i-1];
    end

    // Tag delay line aligned with the codebook ROM latency.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < CB_LAT; i++) cb_tag[i] <= '0;
        end else begin
            cb_tag[0] <= iss;
            for (int i = 1; i < CB_LAT; i++) cb_tag[i] <= cb_tag[i-1];
        end
    end

    // Registered mac_ants inputs: vector, code word and valid move together.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_mac_valid     <= 1'b0;
            o_mac_ants_data <= '0;
            o_mac_code_word <= '0;
            mac_tag         <= '0;
        end else begin
            o_mac_valid <= cb_tag[CB_LAT-1].valid;
            mac_tag     <= cb_tag[CB_LAT-1];
            if (cb_tag[CB_LAT-1].valid) begin
                o_mac_ants_data <= cb_vec[CB_LAT-1];
                o_mac_code_word <= i_cb_data;
            end
        end
    end

    // Tag delay line matching the mac_ants latency.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < MAC_LAT; i++) res_tag[i] <= '0;
        end else begin
            res_tag[0] <= mac_tag;
            for (int i = 1; i < MAC_LAT; i++) res_tag[i] <= res_tag[i-1];
        end
    end

    // Registered result outputs; o_tdata and o_beam_idx hold between beats.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_tvalid   <= 1'b0;
            o_tdata    <= '0;
            o_beam_idx <= '0;
            o_sop      <= 1'b0;
            o_eop      <= 1'b0;
        end else begin
            o_tvalid <= res_tag[MAC_LAT-1].valid;
            o_sop    <= res_tag[MAC_LAT-1].valid && res_tag[MAC_LAT-1].sop;
            o_eop    <= res_tag[MAC_LAT-1].valid && res_tag[MAC_LAT-1].eop;
            if (res_tag[MAC_LAT-1].valid) begin
                o_tdata    <= i_mac_sum;
                o_beam_idx <= res_tag[MAC_LAT-1].idx;
            end
        end
    end

`ifdef MAC_ANTS_SCHED_STAT_EN
    logic any_valid;

    // Any beam still in flight anywhere in the delay lines.
    always_comb begin
        any_valid = mac_tag.valid;
        for (int i = 0; i < CB_LAT; i++)  any_valid = any_valid | cb_tag[i].valid;
        for (int i = 0; i < MAC_LAT; i++) any_valid = any_valid | res_tag[i].valid;
    end

    // Completed-vector counter and busy flag.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_vec_cnt <= '0;
            o_busy    <= 1'b0;
        end else begin
            if (o_tvalid && o_eop) o_vec_cnt <= o_vec_cnt + 16'd1;
            o_busy <= (state == RUN) || any_valid;
        end
    end
`endif

endmodule

// File: tb/tb_mac_ants_sched.sv
// Self-checking bench for mac_ants_sched: codebook ROM and mac_ants models,
// a beat-level scoreboard, directed sequences, an nbeam table and random sweeps.
module tb_mac_ants_sched;

    localparam int ANT = 32, IW = 32, OW = 48, NBEAM = 16, BW = 4;
    localparam int CB_LAT = 1, MAC_LAT = 10;
    localparam int DW = ANT * IW;
    localparam int PIPE = CB_LAT + MAC_LAT + 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [DW-1:0]   ants_data = '0;
    logic            rvalid = 1'b0;
    logic            ready;
    logic [BW:0]     nbeam = '0;
    logic [BW-1:0]   cb_addr;
    logic            cb_rden;
    logic [DW-1:0]   cb_data;
    logic [DW-1:0]   mac_ants_data, mac_code_word;
    logic            mac_valid;
    logic [2*OW-1:0] mac_sum;
    logic            tvalid;
    logic [2*OW-1:0] tdata;
    logic [BW-1:0]   beam_idx;
    logic            sop, eop;
`ifdef MAC_ANTS_SCHED_STAT_EN
    logic [15:0]     vec_cnt;
    logic            busy;
`endif

    mac_ants_sched #(.ANT(ANT), .IW(IW), .OW(OW), .NBEAM(NBEAM), .BW(BW),
                     .CB_LAT(CB_LAT), .MAC_LAT(MAC_LAT)) dut (
        .i_clk(clk), .i_reset(rst), .i_ants_data(ants_data), .i_rvalid(rvalid),
        .o_ready(ready), .i_nbeam(nbeam), .o_cb_addr(cb_addr), .o_cb_rden(cb_rden),
        .i_cb_data(cb_data), .o_mac_ants_data(mac_ants_data),
        .o_mac_code_word(mac_code_word), .o_mac_valid(mac_valid), .i_mac_sum(mac_sum),
        .o_tvalid(tvalid), .o_tdata(tdata), .o_beam_idx(beam_idx), .o_sop(sop),
`ifdef MAC_ANTS_SCHED_STAT_EN
        .o_vec_cnt(vec_cnt), .o_busy(busy),
`endif
        .o_eop(eop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Complex dot product: sum over antennas of vector * code word.
    function automatic logic [95:0] mac_fn(input logic [DW-1:0] a, input logic [DW-1:0] c);
        longint re, im;
        logic signed [15:0] ar, ai, cr, ci;
        logic [63:0] ru, iu;
        re = 0;
        im = 0;
        for (int i = 0; i < ANT; i++) begin
            ar = a[i*IW+16 +: 16];
            ai = a[i*IW +: 16];
            cr = c[i*IW+16 +: 16];
            ci = c[i*IW +: 16];
            re += longint'(ar) * longint'(cr) - longint'(ai) * longint'(ci);
            im += longint'(ar) * longint'(ci) + longint'(ai) * longint'(cr);
        end
        ru = re;
        iu = im;
        return {ru[47:0], iu[47:0]};
    endfunction

    function automatic logic [DW-1:0] rand_vec();
        logic [DW-1:0] v;
        for (int i = 0; i < ANT; i++) v[i*IW +: IW] = $urandom;
        return v;
    endfunction

    function automatic logic [DW-1:0] fill_vec(input logic [31:0] w);
        logic [DW-1:0] v;
        for (int i = 0; i < ANT; i++) v[i*IW +: IW] = w;
        return v;
    endfunction

    // Codebook ROM model with CB_LAT read latency.
    logic [DW-1:0] cb_mem  [NBEAM];
    logic [DW-1:0] cb_pipe [CB_LAT];
    always @(posedge clk) begin
        cb_pipe[0] <= cb_mem[cb_addr];
        for (int i = 1; i < CB_LAT; i++) cb_pipe[i] <= cb_pipe[i-1];
    end
    assign cb_data = cb_pipe[CB_LAT-1];

    // mac_ants model with MAC_LAT latency.
    logic [95:0] mac_pipe [MAC_LAT];
    always @(posedge clk) begin
        mac_pipe[0] <= mac_valid ? mac_fn(mac_ants_data, mac_code_word) : 96'd0;
        for (int i = 1; i < MAC_LAT; i++) mac_pipe[i] <= mac_pipe[i-1];
    end
    assign mac_sum = mac_pipe[MAC_LAT-1];

    // Scoreboard of expected beats.
    typedef struct {
        int          cyc;
        logic [95:0] data;
        logic [3:0]  idx;
        logic        sop;
        logic        eop;
    } exp_t;

    exp_t sb[$];
    int   beats_seen = 0;
    int   last_eop_idx = -1;

    always @(negedge clk) begin
        exp_t e;
        if (tvalid) begin
            beats_seen++;
            if (eop) last_eop_idx = int'(beam_idx);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat_unexpected: got beat idx %0d at cycle %0d, required none", beam_idx, cyc);
            end else begin
                e = sb.pop_front();
                check("beat_data", tdata, e.data);
                check("beat_tag_idx_sop_eop_cyc", {beam_idx, sop, eop, cyc[15:0]},
                      {e.idx, e.sop, e.eop, e.cyc[15:0]});
            end
        end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL beat_missing: got no beat at cycle %0d, required idx %0d at cycle %0d",
                     cyc, sb[0].idx, sb[0].cyc);
            void'(sb.pop_front());
        end
    end

    // Offer a vector; returns one cycle after the accepting edge with rvalid still high.
    task automatic send(input logic [DW-1:0] vec, input logic [4:0] nb_req, output int acc);
        int n, nb;
        rvalid    = 1'b1;
        ants_data = vec;
        nbeam     = nb_req;
        n = 0;
        while (!ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        acc = cyc;
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got ready=0 after %0d cycles, required 1", n);
        end else begin
            nb = (nb_req == 0 || nb_req > NBEAM) ? NBEAM : int'(nb_req);
            for (int b = 0; b < nb; b++)
                sb.push_back('{acc + 1 + b + PIPE, mac_fn(vec, cb_mem[b]), 4'(b), b == 0, b == nb - 1});
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        rvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_pending", sb.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [4:0] nb_req;
        int         exp_beats;
        int         exp_last;
    } nb_vec_t;

    initial begin
        nb_vec_t tbl[6];
        int k, ka, kb, n, tv_seen;

        tbl[0] = '{5'd0,  16, 15};
        tbl[1] = '{5'd17, 16, 15};
        tbl[2] = '{5'd1,  1,  0};
        tbl[3] = '{5'd31, 16, 15};
        tbl[4] = '{5'd16, 16, 15};
        tbl[5] = '{5'd5,  5,  4};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", ready, 1);
        check("rst_tvalid", tvalid, 0);
        check("rst_rden", cb_rden, 0);
        check("rst_mac_valid", mac_valid, 0);
        check("rst_tdata", tdata, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single nb=4 sweep, constant datapath: re=64, im=0.
        for (int i = 0; i < NBEAM; i++) cb_mem[i] = fill_vec(32'h0002_0000);
        send(fill_vec(32'h0001_0000), 5'd4, k);
        idle();
        for (int i = 0; i < 4; i++) begin
            check("seq_rden", cb_rden, 1);
            check("seq_addr", cb_addr, i);
            check("seq_ready", ready, i == 3);
            @(posedge clk); #1;
        end
        check("seq_rden_after", cb_rden, 0);
        n = 0;
        while (!tvalid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("first_latency", cyc - k, 14);
        check("const_tdata", tdata, {48'd64, 48'd0});
        drain();

        // Back-to-back A, B with nb=2.
        for (int i = 0; i < NBEAM; i++) cb_mem[i] = rand_vec();
        send(rand_vec(), 5'd2, ka);
        send(rand_vec(), 5'd2, kb);
        idle();
        check("b2b_accept_gap", kb - ka, 2);
        drain();

        // nbeam clamp table.
        foreach (tbl[t]) begin
            beats_seen = 0;
            last_eop_idx = -1;
            send(rand_vec(), tbl[t].nb_req, k);
            idle();
            drain();
            check("tbl_beats", beats_seen, tbl[t].exp_beats);
            check("tbl_eop_idx", last_eop_idx, tbl[t].exp_last);
        end

        // Reset during a 16-beam sweep.
        send(rand_vec(), 5'd16, k);
        idle();
        while (cyc < k + 6) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_ready", ready, 1);
        tv_seen = 0;
        for (int i = 0; i < 24; i++) begin
            if (tvalid || cb_rden) tv_seen++;
            @(posedge clk); #1;
        end
        check("rst_mid_quiet", tv_seen, 0);
        send(rand_vec(), 5'd16, k);
        idle();
        drain();

        // Two more sweeps: three completed since the reset.
        send(rand_vec(), 5'd3, k);
        send(rand_vec(), 5'd2, k);
        idle();
`ifdef MAC_ANTS_SCHED_STAT_EN
        n = 0;
        while (!(tvalid && eop && sb.size() == 0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("busy_at_eop", busy, 1);
        @(posedge clk); #1;
        check("busy_after_eop", busy, 0);
`endif
        drain();
`ifdef MAC_ANTS_SCHED_STAT_EN
        check("vec_cnt", vec_cnt, 3);
`endif

        // Random sweeps with random gaps and nbeam values.
        for (int i = 0; i < NBEAM; i++) cb_mem[i] = rand_vec();
        for (int r = 0; r < 24; r++) begin
            send(rand_vec(), 5'($urandom_range(0, 20)), k);
            n = $urandom_range(0, 3);
            if (n > 0) begin
                idle();
                repeat (n) @(posedge clk);
                #1;
            end
        end
        idle();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
